// File: rtl/br_fifo_shared_pool_pkg.sv
// Shared helpers for the shared-pool credit controller: width functions and
// the wide count type used for pool-level sums.
package br_fifo_shared_pool_pkg;

  localparam int CountCalcWidth = 16;

  typedef logic [CountCalcWidth-1:0] fifo_count_t;

  function automatic int clamped_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int fifo_id_width(input int numFifos);
    return clamped_clog2(numFifos);
  endfunction

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/br_fifo_shared_pool_rr_grant.sv
// Multi-grant round-robin arbiter: walks requesters from the pointer, grants up
// to a per-cycle limit, and moves the pointer one past the last grantee.
module br_fifo_shared_pool_rr_grant
  import br_fifo_shared_pool_pkg::*;
#(
  parameter int NumReq    = 2,
  parameter int MaxGrants = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NumReq-1:0] i_request,
  input  fifo_count_t       i_grantLimit,
  output logic [NumReq-1:0] o_grant
);

  localparam int PtrWidth = clamped_clog2(NumReq);

  logic [PtrWidth-1:0] r_ptr;
  logic [PtrWidth-1:0] w_ptrNext;
  logic [PtrWidth-1:0] w_idx;
  fifo_count_t         w_grantCount;

  // Scan starts at the pointer and wraps once around all requesters
  always_comb begin
    o_grant      = '0;
    w_ptrNext    = r_ptr;
    w_idx        = '0;
    w_grantCount = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (int'(r_ptr) + k >= NumReq) begin
        w_idx = PtrWidth'(int'(r_ptr) + k - NumReq);
      end else begin
        w_idx = PtrWidth'(int'(r_ptr) + k);
      end
      if (i_request[w_idx] && (w_grantCount < i_grantLimit) &&
          (w_grantCount < fifo_count_t'(MaxGrants))) begin
        o_grant[w_idx] = 1'b1;
        w_grantCount   = w_grantCount + 1'b1;
        w_ptrNext      = (w_idx == PtrWidth'(NumReq - 1)) ? '0 : w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptrNext;
    end
  end

endmodule

// File: rtl/br_fifo_shared_pool_credit_ctrl.sv
// Per-FIFO credit issuer for a shared-storage multi-FIFO: reserved credits per
// FIFO plus a round-robin share of the remaining pool, capped per FIFO.
module br_fifo_shared_pool_credit_ctrl
  import br_fifo_shared_pool_pkg::*;
#(
  parameter int NumFifos            = 2,
  parameter int Depth               = 8,
  parameter int ReservedPerFifo     = 1,
  parameter int MaxPerFifo          = Depth,
  parameter int NumWritePorts       = 1,
  parameter int NumDeallocPorts     = 1,
  parameter int RegisterPushOutputs = 0,
  localparam int FifoIdWidth        = fifo_id_width(NumFifos),
  localparam int CountWidth         = count_width(Depth)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push_sender_in_reset,
  output logic                                 push_receiver_in_reset,
  input  logic                                 push_credit_stall,
  output logic [NumFifos-1:0]                  push_credit,
  input  logic [NumWritePorts-1:0]             push_valid,
  input  logic [NumWritePorts*FifoIdWidth-1:0] push_fifo_id,
  input  logic [NumDeallocPorts-1:0]           dealloc_valid,
  input  logic [NumDeallocPorts*FifoIdWidth-1:0] dealloc_fifo_id,
  output logic [NumFifos*CountWidth-1:0]       fifo_occupancy,
  output logic [NumFifos*CountWidth-1:0]       sender_credits,
  output logic [CountWidth-1:0]                shared_available
);

  localparam int ArithWidth  = CountWidth + 1;
  localparam int SharedTotal = Depth - NumFifos * ReservedPerFifo;

  logic                  w_localReset;
  logic                  r_receiverInReset;
  logic [CountWidth-1:0] r_occ          [NumFifos];
  logic [CountWidth-1:0] r_held         [NumFifos];
  logic [ArithWidth-1:0] w_pushCount    [NumFifos];
  logic [ArithWidth-1:0] w_deallocCount [NumFifos];
  logic [ArithWidth-1:0] w_outCount     [NumFifos];
  logic [ArithWidth-1:0] w_occNext      [NumFifos];
  logic [ArithWidth-1:0] w_heldNext     [NumFifos];
  logic [NumFifos-1:0]   w_reservedElig;
  logic [NumFifos-1:0]   w_sharedReq;
  logic [NumFifos-1:0]   w_sharedGrant;
  logic [NumFifos-1:0]   w_issue;
  fifo_count_t           w_sharedUsed;
  fifo_count_t           w_sharedAvail;
  fifo_count_t           w_grantLimit;
  fifo_count_t           w_totalOut;

  assign w_localReset = rst | push_sender_in_reset;

  always_comb begin
    for (int i = 0; i < NumFifos; i++) begin
      w_pushCount[i]    = '0;
      w_deallocCount[i] = '0;
      for (int p = 0; p < NumWritePorts; p++) begin
        if (push_valid[p] && (push_fifo_id[p*FifoIdWidth +: FifoIdWidth] == FifoIdWidth'(i))) begin
          w_pushCount[i] = w_pushCount[i] + 1'b1;
        end
      end
      for (int d = 0; d < NumDeallocPorts; d++) begin
        if (dealloc_valid[d] && (dealloc_fifo_id[d*FifoIdWidth +: FifoIdWidth] == FifoIdWidth'(i))) begin
          w_deallocCount[i] = w_deallocCount[i] + 1'b1;
        end
      end
    end
  end

  // Eligibility and pool accounting look only at registered counters, so a
  // push or dealloc influences issue decisions from the following cycle.
  always_comb begin
    w_sharedUsed   = '0;
    w_totalOut     = '0;
    w_reservedElig = '0;
    w_sharedReq    = '0;
    for (int i = 0; i < NumFifos; i++) begin
      w_outCount[i]     = ArithWidth'(r_occ[i]) + ArithWidth'(r_held[i]);
      w_totalOut        = w_totalOut + fifo_count_t'(w_outCount[i]);
      w_reservedElig[i] = w_outCount[i] < ArithWidth'(ReservedPerFifo);
      w_sharedReq[i]    = !w_reservedElig[i] && (w_outCount[i] < ArithWidth'(MaxPerFifo)) &&
                          !w_localReset && !push_credit_stall;
      if (w_outCount[i] > ArithWidth'(ReservedPerFifo)) begin
        w_sharedUsed = w_sharedUsed + fifo_count_t'(w_outCount[i] - ArithWidth'(ReservedPerFifo));
      end
    end
    w_sharedAvail = fifo_count_t'(SharedTotal) - w_sharedUsed;
    w_grantLimit  = (w_sharedAvail < fifo_count_t'(NumWritePorts)) ?
                    w_sharedAvail : fifo_count_t'(NumWritePorts);
  end

  br_fifo_shared_pool_rr_grant #(
    .NumReq   (NumFifos),
    .MaxGrants(NumWritePorts)
  ) u_rrGrant (
    .clk         (clk),
    .rst         (w_localReset),
    .i_request   (w_sharedReq),
    .i_grantLimit(w_grantLimit),
    .o_grant     (w_sharedGrant)
  );

  assign w_issue = (w_localReset || push_credit_stall) ? '0 : (w_reservedElig | w_sharedGrant);

  always_comb begin
    for (int i = 0; i < NumFifos; i++) begin
      w_occNext[i]  = ArithWidth'(r_occ[i]) + w_pushCount[i] - w_deallocCount[i];
      w_heldNext[i] = ArithWidth'(r_held[i]) + ArithWidth'(w_issue[i]) - w_pushCount[i];
    end
  end

  // Credits are charged to held at decision time, even when the output is
  // registered, so the pool never over-issues across the extra stage.
  always_ff @(posedge clk) begin
    r_receiverInReset <= rst;
    for (int i = 0; i < NumFifos; i++) begin
      if (w_localReset) begin
        r_occ[i]  <= '0;
        r_held[i] <= '0;
      end else begin
        r_occ[i]  <= w_occNext[i][CountWidth-1:0];
        r_held[i] <= w_heldNext[i][CountWidth-1:0];
      end
    end
  end

  if (RegisterPushOutputs != 0) begin : gen_regOut
    logic [NumFifos-1:0] r_pushCredit;
    always_ff @(posedge clk) begin
      if (w_localReset) begin
        r_pushCredit <= '0;
      end else begin
        r_pushCredit <= w_issue;
      end
    end
    assign push_credit = r_pushCredit & ~{NumFifos{w_localReset}};
  end else begin : gen_combOut
    assign push_credit = w_issue;
  end

  for (genvar i = 0; i < NumFifos; i++) begin : gen_pack
    assign fifo_occupancy[i*CountWidth +: CountWidth] = r_occ[i];
    assign sender_credits[i*CountWidth +: CountWidth] = r_held[i];
  end

  assign shared_available       = w_sharedAvail[CountWidth-1:0];
  assign push_receiver_in_reset = r_receiverInReset;

  for (genvar i = 0; i < NumFifos; i++) begin : gen_assert
    assert property (@(posedge clk) disable iff (w_localReset)
      (w_pushCount[i] != '0) |-> (r_held[i] != '0));
    assert property (@(posedge clk) disable iff (w_localReset)
      (w_deallocCount[i] != '0) |-> (r_occ[i] != '0));
    assert property (@(posedge clk) disable iff (w_localReset)
      !w_occNext[i][CountWidth] && !w_heldNext[i][CountWidth]);
    assert property (@(posedge clk) disable iff (w_localReset)
      w_outCount[i] <= ArithWidth'(MaxPerFifo));
  end

  assert property (@(posedge clk) disable iff (w_localReset) w_totalOut <= fifo_count_t'(Depth));

endmodule

// File: doc/br_fifo_shared_pool_credit_ctrl.md
# br_fifo_shared_pool_credit_ctrl

Per-FIFO credit issuer for a shared-storage multi-FIFO. It generalises the single shared `push_credit` return into one credit stream per logical FIFO. Each FIFO gets a guaranteed reservation and a per-FIFO occupancy cap; the remaining shared pool is distributed round-robin. It sits on the push side of a shared dynamic multi-FIFO, between the upstream sender and the storage controller, and consumes the controller's deallocation events.

## Interface
Parameters:
- `NumFifos`, 2: logical FIFOs; must be >=2.
- `Depth`, 8: total shared entries; must be >= `NumFifos*ReservedPerFifo`.
- `ReservedPerFifo`, 1: entries guaranteed to each FIFO; >=0.
- `MaxPerFifo`, `Depth`: cap on outstanding entries per FIFO; `ReservedPerFifo` <= `MaxPerFifo` <= `Depth`.
- `NumWritePorts`, 1: pushes accepted per cycle, and the maximum number of shared-pool grants per cycle; >=1.
- `NumDeallocPorts`, 1: deallocation events per cycle; >=1.
- `RegisterPushOutputs`, 0: when 1, `push_credit` is driven from a flop.
- Localparams: `FifoIdWidth = br_math::clamped_clog2(NumFifos)`, `CountWidth = $clog2(Depth+1)`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset; synchronous, active-high.
- `push_sender_in_reset` in 1: sender is in reset; treated as a local reset.
- `push_receiver_in_reset` out 1: flop; reset value 1; next-state value = `rst`.
- `push_credit_stall` in 1: while high, no credits are issued.
- `push_credit` out `NumFifos`: one credit per FIFO per cycle; reset value 0.
- `push_valid` in `NumWritePorts`: a push arrives.
- `push_fifo_id` in `NumWritePorts*FifoIdWidth`: destination FIFO of each push.
- `dealloc_valid` in `NumDeallocPorts`: an entry is freed by the pop side.
- `dealloc_fifo_id` in `NumDeallocPorts*FifoIdWidth`: owning FIFO of each freed entry.
- `fifo_occupancy` out `NumFifos*CountWidth`: stored entries per FIFO; reset value 0.
- `sender_credits` out `NumFifos*CountWidth`: credits the sender holds per FIFO; reset value 0.
- `shared_available` out `CountWidth`: free shared-pool entries; reset value `Depth - NumFifos*ReservedPerFifo`.

## Operation
- Per-FIFO counters are registered:
  - `occ[i] += pushes(i) - deallocs(i)`.
  - `held[i] += issued(i) - pushes(i)`.
  - `out[i] = occ[i] + held[i]`.
- `shared_used = sum over i of max(0, out[i] - ReservedPerFifo)`. `shared_available = Depth - NumFifos*ReservedPerFifo - shared_used`.
- Eligibility is computed from registered state only:
  - FIFO i gets a reserved credit if `out[i] < ReservedPerFifo`.
  - Otherwise it is a shared candidate if `out[i] < MaxPerFifo`.
- Reserved credits are issued to every eligible FIFO each cycle. They do not consume shared grants.
- Shared grants go to candidates in round-robin order starting at `rr_ptr`. At most `min(NumWritePorts, shared_available)` are granted per cycle.
- `rr_ptr` moves to one past the last shared grantee. It is unchanged if there is no shared grant.
- Each FIFO receives at most 1 credit per cycle.
- Multiple pushes or deallocs to the same FIFO in one cycle are summed. Counter arithmetic is done at `CountWidth+1` bits; no wrap is permitted.
- A dealloc or push in cycle N affects eligibility from cycle N+1.
- If `rst || push_sender_in_reset`:
  - all counters and `rr_ptr` clear;
  - `push_credit` = 0;
  - any in-flight registered credit is discarded.
- Assertions:
  - push to FIFO i with `held[i]` = 0;
  - dealloc to FIFO i with `occ[i]` = 0;
  - `sum(out) <= Depth` at all times;
  - `out[i] <= MaxPerFifo`.

## Timing
- With `RegisterPushOutputs`=0, `push_credit` is combinational from the registered counters, `push_credit_stall`, and reset. Credits can be issued in the first cycle after reset deasserts.
- With `RegisterPushOutputs`=1, credits are delayed by 1 cycle. Counters are charged at decision time, so there is no overcount.
- Dealloc-to-credit latency: 1 cycle, plus `RegisterPushOutputs`.
- `push_credit_stall` blocks issue in the same cycle. Counters and `rr_ptr` hold their values.

## Structure
- Package `br_fifo_shared_pool_pkg`: `FifoIdWidth`/`CountWidth` helper functions and a `fifo_count_t` typedef.
- Sub-module `br_fifo_shared_pool_rr_grant`: multi-grant round-robin arbiter, up to N grants per cycle, with pointer update.
- The top level holds the counters, eligibility logic, popcount adders and output register.

## Test plan
- `NumFifos`=2, `Depth`=8, `ReservedPerFifo`=2, `MaxPerFifo`=6, `NumWritePorts`=1, no pushes, reset released:
  - cycles 1–2: `push_credit`=2'b11;
  - cycles 3–6: credits to FIFO0, FIFO1, FIFO0, FIFO1;
  - then 0, with `shared_available`=0.
- `ReservedPerFifo`=0, `MaxPerFifo`=3, `Depth`=8: each FIFO receives exactly 3 credits; `shared_available` settles at 2.
- After the first scenario saturates: push 1 to FIFO0, then dealloc 1 from FIFO0 → exactly one credit, 1 cycle later, to the FIFO at `rr_ptr` (FIFO0). Occupancy returns to 0.
- `push_credit_stall`=1 for 5 cycles after reset → `push_credit`=0 and all counters 0. On release, the first scenario's sequence resumes unchanged.
- `push_sender_in_reset` pulsed mid-run, with 8 credits outstanding → counters clear and `push_credit`=0 during the pulse. After release, 8 credits are reissued.
- `RegisterPushOutputs`=1, first-scenario configuration → identical credit sequence shifted by 1 cycle, with the same totals.
